// File: rtl/multicycle_cpu_core_if.sv
// Instruction-memory port of multicycle_cpu_core: the core drives the word
// address and the memory answers combinationally with the instruction word.
interface multicycle_cpu_core_if #(
    parameter int IMEM_DEPTH = 256
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/multicycle_cpu_core.sv
// Multicycle RV32I-subset core (ADD/SUB/AND/OR/XOR/SLT and immediate forms),
// paced by step_en. Define CPU_BRANCH_EN to add BEQ/BNE support.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_FETCH     | latch instruction word from imem
// S_DECODE    | decode, read operands, halt on illegal encoding
// S_EXECUTE   | compute ALU result (or branch condition)
// S_WRITEBACK | write rd, publish result, advance pc
// S_HALT      | terminal after an illegal instruction, left only by reset
module multicycle_cpu_core #(
    parameter int  XLEN       = 32,
    parameter int  NREGS      = 32,
    parameter int  IMEM_DEPTH = 256,
    localparam int AW         = $clog2(IMEM_DEPTH),
    localparam int PCW        = AW + 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step_en,
    multicycle_cpu_core_if.master        imem,
    output logic [PCW-1:0]               pc,
    output logic [XLEN-1:0]              result,
    output logic                         result_valid,
    output logic                         halted
);
    localparam int               RW      = $clog2(NREGS);
    localparam logic [5:0]       NREGS_W = 6'(NREGS);
    localparam logic [PCW-1:0]   PC_STEP = PCW'(4);
    localparam logic [6:0]       OPC_OP     = 7'b0110011;
    localparam logic [6:0]       OPC_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
    } alu_op_e;

    state_e          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] a, b, imm, y;
    logic [RW-1:0]   rd_q;
    alu_op_e         alu_op;
    logic            use_imm;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic            rs1_ok, rs2_ok, rd_ok;
    logic            dec_legal, dec_use_imm;
    alu_op_e         dec_op;
    logic [XLEN-1:0] imm_i, alu_b, alu_y;

    assign opcode = ir[6:0];
    assign rd_f   = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1_f  = ir[19:15];
    assign rs2_f  = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign rs1_ok = {1'b0, rs1_f} < NREGS_W;
    assign rs2_ok = {1'b0, rs2_f} < NREGS_W;
    assign rd_ok  = {1'b0, rd_f}  < NREGS_W;

    assign imem.imem_addr = pc[PCW-1:2];

`ifdef CPU_BRANCH_EN
    localparam logic [6:0]     OPC_BRANCH = 7'b1100011;
    localparam logic [PCW-1:0] ALIGN_MASK = ~PCW'(3);

    logic                is_branch, br_ne, cond, dec_branch;
    logic [PCW-1:0]      br_off;
    logic signed [12:0]  imm_b;
    logic [PCW-1:0]      br_target;

    assign imm_b     = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign br_target = (pc + br_off) & ALIGN_MASK;
`endif

    always_comb begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_op      = ALU_ADD;
`ifdef CPU_BRANCH_EN
        dec_branch  = 1'b0;
`endif
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_op = ALU_ADD;
                        3'b010:  dec_op = ALU_SLT;
                        3'b100:  dec_op = ALU_XOR;
                        3'b110:  dec_op = ALU_OR;
                        3'b111:  dec_op = ALU_AND;
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SUB;
                end
                dec_legal = dec_legal && rs1_ok && rs2_ok && rd_ok;
            end
            OPC_OP_IMM: begin
                dec_use_imm = 1'b1;
                dec_legal   = 1'b1;
                case (funct3)
                    3'b000:  dec_op = ALU_ADD;
                    3'b010:  dec_op = ALU_SLT;
                    3'b100:  dec_op = ALU_XOR;
                    3'b110:  dec_op = ALU_OR;
                    3'b111:  dec_op = ALU_AND;
                    default: dec_legal = 1'b0;
                endcase
                dec_legal = dec_legal && rs1_ok && rd_ok;
            end
`ifdef CPU_BRANCH_EN
            OPC_BRANCH: begin
                dec_branch = 1'b1;
                dec_legal  = (funct3 == 3'b000 || funct3 == 3'b001) && rs1_ok && rs2_ok;
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_b = use_imm ? imm : b;
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = a + alu_b;
            ALU_SUB: alu_y = a - alu_b;
            ALU_AND: alu_y = a & alu_b;
            ALU_OR:  alu_y = a | alu_b;
            ALU_XOR: alu_y = a ^ alu_b;
            ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(alu_b)};
            default: alu_y = '0;
        endcase
    end

    // result_valid is cleared every clk so the write-back pulse lasts one
    // cycle even when step_en drops right after it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            pc           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            halted       <= 1'b0;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            imm          <= '0;
            y            <= '0;
            rd_q         <= '0;
            alu_op       <= ALU_ADD;
            use_imm      <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef CPU_BRANCH_EN
            is_branch    <= 1'b0;
            br_ne        <= 1'b0;
            br_off       <= '0;
            cond         <= 1'b0;
`endif
        end else begin
            result_valid <= 1'b0;
            if (step_en) begin
                case (state)
                    S_FETCH: begin
                        ir    <= imem.imem_rdata;
                        state <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (!dec_legal) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            a       <= regs[rs1_f[RW-1:0]];
                            b       <= regs[rs2_f[RW-1:0]];
                            imm     <= imm_i;
                            rd_q    <= rd_f[RW-1:0];
                            alu_op  <= dec_op;
                            use_imm <= dec_use_imm;
`ifdef CPU_BRANCH_EN
                            is_branch <= dec_branch;
                            br_ne     <= funct3[0];
                            br_off    <= PCW'(imm_b);
`endif
                            state   <= S_EXECUTE;
                        end
                    end
                    S_EXECUTE: begin
                        y     <= alu_y;
`ifdef CPU_BRANCH_EN
                        cond  <= (a == b) ^ br_ne;
`endif
                        state <= S_WRITEBACK;
                    end
                    S_WRITEBACK: begin
`ifdef CPU_BRANCH_EN
                        if (is_branch) begin
                            pc <= cond ? br_target : pc + PC_STEP;
                        end else begin
                            if (rd_q != '0) regs[rd_q] <= y;
                            result       <= y;
                            result_valid <= 1'b1;
                            pc           <= pc + PC_STEP;
                        end
`else
                        if (rd_q != '0) regs[rd_q] <= y;
                        result       <= y;
                        result_valid <= 1'b1;
                        pc           <= pc + PC_STEP;
`endif
                        state <= S_FETCH;
                    end
                    S_HALT: state <= S_HALT;
                    default: begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Self-checking bench for multicycle_cpu_core: directed programs plus random
// programs compared against an instruction-level reference model.
module tb_multicycle_cpu_core;
    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int DEPTH = 64;
    localparam int PCW   = 8;
    localparam int PCMOD = 1 << PCW;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             step_en = 1'b0;
    logic [PCW-1:0]   pc;
    logic [XLEN-1:0]  result;
    logic             result_valid;
    logic             halted;
    logic [31:0]      mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    // reference model: architectural state only
    logic [31:0] m_regs [NREGS];
    int          m_pc;
    logic [31:0] m_result;
    bit          m_halted;

    multicycle_cpu_core_if #(.IMEM_DEPTH(DEPTH)) imem_bus ();
    assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];

    multicycle_cpu_core #(.XLEN(XLEN), .NREGS(NREGS), .IMEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .step_en      (step_en),
        .imem         (imem_bus),
        .pc           (pc),
        .result       (result),
        .result_valid (result_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_pc = 0;
        m_result = '0;
        m_halted = 0;
    endtask

    // Executes the instruction at m_pc in the model; reports legality and pulse.
    task automatic model_exec(output bit legal, output bit pulse);
        logic [31:0] ir, a, b, immi, yv;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        int rd, rs1, rs2, immb, npc;
        bit taken;
        ir   = mem[(m_pc >> 2) % DEPTH];
        op   = ir[6:0];
        f3   = ir[14:12];
        f7   = ir[31:25];
        rd   = int'(ir[11:7]);
        rs1  = int'(ir[19:15]);
        rs2  = int'(ir[24:20]);
        immi = {{20{ir[31]}}, ir[31:20]};
        immb = int'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
        a    = (rs1 < NREGS) ? m_regs[rs1] : '0;
        b    = (rs2 < NREGS) ? m_regs[rs2] : '0;
        legal = 0;
        pulse = 0;
        yv    = '0;
        npc   = (m_pc + 4) % PCMOD;
        if (op == 7'h33) begin
            legal = 1;
            case ({f7, f3})
                {7'h00, 3'd0}: yv = a + b;
                {7'h20, 3'd0}: yv = a - b;
                {7'h00, 3'd2}: yv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                {7'h00, 3'd4}: yv = a ^ b;
                {7'h00, 3'd6}: yv = a | b;
                {7'h00, 3'd7}: yv = a & b;
                default:       legal = 0;
            endcase
            legal = legal && rs1 < NREGS && rs2 < NREGS && rd < NREGS;
            pulse = legal;
        end else if (op == 7'h13) begin
            legal = 1;
            case (f3)
                3'd0: yv = a + immi;
                3'd2: yv = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                3'd4: yv = a ^ immi;
                3'd6: yv = a | immi;
                3'd7: yv = a & immi;
                default: legal = 0;
            endcase
            legal = legal && rs1 < NREGS && rd < NREGS;
            pulse = legal;
        end
`ifdef CPU_BRANCH_EN
        else if (op == 7'h63) begin
            legal = (f3 == 3'd0 || f3 == 3'd1) && rs1 < NREGS && rs2 < NREGS;
            taken = (f3 == 3'd0) ? (a == b) : (a != b);
            if (taken) npc = ((((m_pc + immb) % PCMOD) + PCMOD) % PCMOD) & ~3;
        end
`endif
        if (!legal) begin
            m_halted = 1;
        end else begin
            if (pulse) begin
                if (rd != 0) m_regs[rd] = yv;
                m_result = yv;
            end
            m_pc = npc;
        end
    endtask

    // Runs one instruction on DUT and model; mode<0 enables one cycle in four,
    // otherwise step_en is high with probability mode percent.
    task automatic do_instr(input int mode, output int ncyc);
        bit legal, pulse, en;
        int need, done, old_pc;
        logic [31:0] old_result;
        old_pc     = m_pc;
        old_result = m_result;
        model_exec(legal, pulse);
        need = legal ? 4 : 2;
        done = 0;
        ncyc = 0;
        while (done < need) begin
            @(negedge clk);
            if (mode < 0) en = (ncyc % 4 == 3);
            else          en = ($urandom_range(0, 99) < mode) || ncyc > 40;
            step_en = en;
            @(posedge clk);
            #1;
            ncyc++;
            if (en) done++;
            check("result_valid", result_valid, en && done == 4 && pulse);
            check("halted", halted, !legal && done >= 2);
            check("pc", pc, (done == 4) ? m_pc : old_pc);
            check("result", result, (done == 4 && pulse) ? m_result : old_result);
        end
        @(negedge clk);
        step_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        model_reset();
        check("rst_pc", pc, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_halted", halted, 0);
        @(negedge clk);
        step_en = 0;
        reset = 1'b1;
    endtask

    task automatic load_prog(input logic [31:0] p [$]);
        for (int i = 0; i < DEPTH; i++) mem[i] = (i < p.size()) ? p[i] : 32'h0;
    endtask

    function automatic logic [31:0] rand_instr(input bit allow_bad);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [12:0] bimm;
        int k;
        k   = $urandom_range(0, 39);
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        if (allow_bad && $urandom_range(0, 19) == 0) rd = 5'($urandom_range(NREGS, 31));
        if (!allow_bad) k = k % 38;
        case (k % 40)
            0, 1:   return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            2, 3:   return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            4, 5:   return {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
            6, 7:   return {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
            8, 9:   return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            10, 11: return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
            12, 13, 14, 15, 16, 17: return {imm, rs1, 3'd0, rd, 7'h13};
            18, 19, 20, 21: return {imm, rs1, 3'd2, rd, 7'h13};
            22, 23, 24, 25: return {imm, rs1, 3'd4, rd, 7'h13};
            26, 27, 28, 29: return {imm, rs1, 3'd6, rd, 7'h13};
            30, 31, 32, 33: return {imm, rs1, 3'd7, rd, 7'h13};
            34, 35, 36, 37: return {imm, 5'd0, 3'd0, rd, 7'h13};
            38: begin
                bimm = 13'(($urandom_range(0, 15) - 8) * 4 + $urandom_range(0, 1) * 2);
                return {bimm[12], bimm[10:5], rs2, rs1, 3'($urandom_range(0, 1)),
                        bimm[4:1], bimm[11], 7'h63};
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prog [$];
        int ncyc, total;

        // reset state and basic pipeline timing
        reset = 1'b0;
        #12;
        do_reset();
        prog = '{32'h00500093, 32'h00108133};
        load_prog(prog);
        do_instr(100, ncyc);
        check("tp1_cycles", ncyc, 4);
        check("tp1_result", result, 32'd5);
        check("tp1_pc", pc, 4);
        do_instr(100, ncyc);
        check("tp1b_result", result, 32'd10);
        check("tp1b_pc", pc, 8);

        // signed immediates, SLTI, SUB
        do_reset();
        prog = '{32'hFFF00193, 32'h0011A213, 32'h403002B3};
        load_prog(prog);
        do_instr(100, ncyc);
        check("tp2_addi", result, 32'hFFFFFFFF);
        do_instr(100, ncyc);
        check("tp2_slti", result, 32'd1);
        do_instr(100, ncyc);
        check("tp2_sub", result, 32'd1);

        // branch loop (legal only with branch support)
        do_reset();
        prog = '{32'h00100093, 32'hFE009EE3};
        load_prog(prog);
        total = 0;
        for (int i = 0; i < 6 && !m_halted; i++) begin
            do_instr(100, ncyc);
            total += ncyc;
        end
`ifdef CPU_BRANCH_EN
        check("tp3_halted", halted, 0);
        check("tp3_pc", pc, 0);
`else
        check("tp3_halted", halted, 1);
        check("tp3_pc", pc, 4);
        check("tp3_cycles", total, 6);
`endif

        // zero word is illegal, halt is sticky and silent
        do_reset();
        prog = '{32'h00000000};
        load_prog(prog);
        do_instr(100, ncyc);
        check("tp4_cycles", ncyc, 2);
        step_en = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("tp4_hold_halted", halted, 1);
            check("tp4_hold_valid", result_valid, 0);
            check("tp4_hold_pc", pc, 0);
        end
        step_en = 0;

        // register index beyond NREGS is illegal
        do_reset();
        prog = '{32'h00100813};
        load_prog(prog);
        do_instr(100, ncyc);
        check("tp_bad_rd_halted", halted, 1);

        // paced by one-in-four step_en
        do_reset();
        prog = '{32'h00700093};
        load_prog(prog);
        do_instr(-1, ncyc);
        check("tp5_cycles", ncyc, 16);
        check("tp5_result", result, 32'd7);

        // reset during EXECUTE discards the pending write to x1
        do_reset();
        prog = '{32'h00300293, 32'h00700093};
        load_prog(prog);
        do_instr(100, ncyc);
        @(negedge clk);
        step_en = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("tp5_pre_rst_pc", pc, 4);
        check("tp5_pre_rst_result", result, 32'd3);
        do_reset();
        prog = '{32'h00008133};
        load_prog(prog);
        do_instr(100, ncyc);
        check("tp5_x1_zero", result, 32'd0);

        // writes to x0 still pulse but x0 stays zero
        do_reset();
        prog = '{32'h00900013, 32'h00000333};
        load_prog(prog);
        do_instr(100, ncyc);
        check("tp6_x0_result", result, 32'd9);
        do_instr(100, ncyc);
        check("tp6_add_zero", result, 32'd0);

        // random programs: one long legal run that wraps the pc, then mixed runs
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) mem[i] = rand_instr(r != 0);
            for (int i = 0; i < (r == 0 ? 70 : 40) && !m_halted; i++)
                do_instr($urandom_range(50, 100), ncyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
